// File: rtl/tone_freq_meter_pkg.sv
// Shared constants and FSM encoding for the tone frequency meter.
// Build option: FREQ_METER_DEGLITCH_EN selects the deglitched edge path,
// which lengthens the SETTLE phase from 2 to 4 cycles.
package tone_freq_meter_pkg;

    localparam int unsigned CLK_FREQ_HZ           = 40_000_000;
    localparam int unsigned FREQ_METER_GATE_1S    = CLK_FREQ_HZ;
    localparam int unsigned FREQ_METER_GATE_WIDTH = $clog2(FREQ_METER_GATE_1S);
    localparam int unsigned FREQ_METER_WIDTH      = 16;

`ifdef FREQ_METER_DEGLITCH_EN
    localparam int unsigned SETTLE_CYCLES = 4;
`else
    localparam int unsigned SETTLE_CYCLES = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

endpackage

// File: rtl/tone_sync_edge.sv
// Synchronizes the asynchronous tone input and emits a one-cycle pulse per
// rising edge. Build option FREQ_METER_DEGLITCH_EN adds a 3-sample level
// filter in front of the edge detector.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   tone_in in   asynchronous tone input
//   rise_c  out  rising-edge pulse (combinational from flops)
module tone_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic tone_in,
    output logic rise_c
);

    logic s1;
    logic s2;
    logic s3;

    // Two-flop synchronizer followed by the edge-history flop
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tone_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

`ifdef FREQ_METER_DEGLITCH_EN
    logic s4;
    logic filt;
    logic filt_d;

    // Filtered level only moves once s2, s3, s4 agree (3 equal samples)
    always_ff @(posedge clk) begin
        if (rst) begin
            s4     <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
        end else begin
            s4 <= s3;
            if ((s2 == s3) && (s3 == s4)) begin
                filt <= s2;
            end
            filt_d <= filt;
        end
    end

    assign rise_c = filt & ~filt_d;
`else
    assign rise_c = s2 & ~s3;
`endif

endmodule

// File: rtl/tone_freq_meter.sv
// Counts rising edges of an external tone over back-to-back gate windows of
// GATE_CYCLES clocks and reports the count (Hz for a 1 s gate).
// Build option: FREQ_METER_DEGLITCH_EN (deglitched edges, 4-cycle SETTLE).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   en         in   measurement enable, level
//   tone_in    in   asynchronous tone input
//   freq       out  last completed window edge count, saturated
//   freq_valid out  one-cycle pulse when freq updates
//   overflow   out  last completed window saturated
//   busy       out  high in SETTLE/MEASURE
module tone_freq_meter
    import tone_freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = FREQ_METER_GATE_1S,
    parameter int unsigned GATE_WIDTH  = FREQ_METER_GATE_WIDTH,
    parameter int unsigned FREQ_WIDTH  = FREQ_METER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  tone_in,
    output logic [FREQ_WIDTH-1:0] freq,
    output logic                  freq_valid,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned           SUM_W       = FREQ_WIDTH + 1;
    localparam logic [GATE_WIDTH-1:0] GATE_LAST   = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [1:0]            SETTLE_LAST = 2'(SETTLE_CYCLES - 1);
    localparam logic [FREQ_WIDTH-1:0] CNT_MAX     = '1;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              settle_cnt;
    logic [GATE_WIDTH-1:0]   gate_cnt;
    logic [FREQ_WIDTH-1:0]   edge_cnt;
    logic                    ovf;
    logic                    rise_c;
    logic                    settle_run_c;
    logic                    cnt_run_c;
    logic                    terminal_c;
    logic [SUM_W-1:0]        sum_c;
    logic                    sat_hit_c;
    logic [FREQ_WIDTH-1:0]   freq_sat_c;

    tone_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .tone_in (tone_in),
        .rise_c  (rise_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping en returns to IDLE from any state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!en)                            state_nxt = ST_IDLE;
                else if (settle_cnt == SETTLE_LAST) state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (!en) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath controls decoded from state
    always_comb begin
        settle_run_c = 1'b0;
        cnt_run_c    = 1'b0;
        terminal_c   = 1'b0;
        case (state)
            ST_SETTLE: begin
                settle_run_c = en;
            end
            ST_MEASURE: begin
                cnt_run_c  = en;
                terminal_c = en && (gate_cnt == GATE_LAST);
            end
            default: ;
        endcase
    end

    // Closing count includes an edge landing in the terminal cycle
    always_comb begin
        sum_c      = SUM_W'(edge_cnt) + SUM_W'(rise_c);
        sat_hit_c  = sum_c[SUM_W-1];
        freq_sat_c = sat_hit_c ? CNT_MAX : sum_c[FREQ_WIDTH-1:0];
    end

    // Counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= 2'd0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            settle_cnt <= settle_run_c ? settle_cnt + 2'd1 : 2'd0;

            if (cnt_run_c && !terminal_c) begin
                gate_cnt <= gate_cnt + GATE_WIDTH'(1);
                if (rise_c) begin
                    if (edge_cnt == CNT_MAX) begin
                        ovf <= 1'b1;
                    end else begin
                        edge_cnt <= edge_cnt + FREQ_WIDTH'(1);
                    end
                end
            end else begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf      <= 1'b0;
            end

            freq_valid <= terminal_c;
            if (terminal_c) begin
                freq     <= freq_sat_c;
                overflow <= ovf | sat_hit_c;
            end

            busy <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_tone_freq_meter.sv
// Directed bench for tone_freq_meter: two instances (16-bit and 4-bit result)
// share one tone; expected window results are queued when stimulus is set
// up and popped when freq_valid pulses.
module tb_tone_freq_meter;

`ifdef FREQ_METER_DEGLITCH_EN
    localparam int SETTLE   = 4;
    localparam bit DEGLITCH = 1'b1;
`else
    localparam int SETTLE   = 2;
    localparam bit DEGLITCH = 1'b0;
`endif

    typedef struct {
        int   f;
        logic o;
        bit   chk_f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tone;
    logic [15:0] freq_a;
    logic        fv_a;
    logic        ovf_a;
    logic        busy_a;
    logic [3:0]  freq_b;
    logic        fv_b;
    logic        ovf_b;
    logic        busy_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   tone_period;
    int   tone_high;
    int   ph;
    logic tone_hold;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    tone_freq_meter #(.GATE_CYCLES(100), .GATE_WIDTH(7), .FREQ_WIDTH(16)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tone_in    (tone),
        .freq       (freq_a),
        .freq_valid (fv_a),
        .overflow   (ovf_a),
        .busy       (busy_a)
    );

    tone_freq_meter #(.GATE_CYCLES(100), .GATE_WIDTH(7), .FREQ_WIDTH(4)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tone_in    (tone),
        .freq       (freq_b),
        .freq_valid (fv_b),
        .overflow   (ovf_b),
        .busy       (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample point is 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (tone_period == 0) begin
            tone = tone_hold;
        end else begin
            ph   = (ph + 1) % tone_period;
            tone = (ph < tone_high);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_tone(input int period, input int high, input logic hold);
        tone_period = period;
        tone_high   = high;
        tone_hold   = hold;
        ph          = 0;
    endtask

    task automatic push(input int fa, input logic oa, input bit ca,
                        input int fb, input logic ob, input int n);
        exp_t ea;
        exp_t eb;
        for (int i = 0; i < n; i++) begin
            ea.f = fa; ea.o = oa; ea.chk_f = ca;
            eb.f = fb; eb.o = ob; eb.chk_f = 1'b1;
            q_a.push_back(ea);
            q_b.push_back(eb);
        end
    endtask

    // Wait for each window pulse (bounded), compare against queued results
    task automatic run_windows(input int n);
        exp_t ea;
        exp_t eb;
        int   cnt;
        for (int w = 0; w < n; w++) begin
            cnt = 0;
            while (fv_a !== 1'b1 && fv_b !== 1'b1 && cnt < 400) begin
                step();
                cnt++;
            end
            check("pulse_a", 32'(fv_a), 32'd1);
            check("pulse_b", 32'(fv_b), 32'd1);
            check("queue_nonempty", 32'(q_a.size() > 0 && q_b.size() > 0), 32'd1);
            if (q_a.size() > 0 && q_b.size() > 0) begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                if (ea.chk_f) check("freq_a", 32'(freq_a), 32'(ea.f));
                check("ovf_a", 32'(ovf_a), 32'(ea.o));
                check("freq_b", 32'(freq_b), 32'(eb.f));
                check("ovf_b", 32'(ovf_b), 32'(eb.o));
            end
            step();
            check("pulse_width_a", 32'(fv_a), 32'd0);
            check("pulse_width_b", 32'(fv_b), 32'd0);
        end
    endtask

    initial begin
        int pulses;
        int lat;

        rst = 1'b1;
        en  = 1'b0;
        set_tone(10, 5, 1'b0);
        tone = 1'b0;

        // Reset with tone toggling
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_freq", 32'(freq_a), 32'd0);
            check("rst_fv", 32'(fv_a), 32'd0);
            check("rst_ovf", 32'(ovf_a), 32'd0);
            check("rst_busy", 32'(busy_a), 32'd0);
            check("rst_fv_b", 32'(fv_b), 32'd0);
        end
        rst = 1'b0;
        steps(20);
        check("idle_busy", 32'(busy_a), 32'd0);

        // Period 10 tone
        en = 1'b1;
        push(10, 1'b0, 1'b1, 10, 1'b0, 3);
        step();
        check("busy_on", 32'(busy_a), 32'd1);
        run_windows(3);
        en = 1'b0;

        // Tone held high
        set_tone(0, 0, 1'b1);
        steps(20);
        en = 1'b1;
        push(0, 1'b0, 1'b1, 0, 1'b0, 2);
        run_windows(2);
        en = 1'b0;

        // Fast tone saturates the 4-bit instance
        if (DEGLITCH) begin
            set_tone(6, 3, 1'b0);
            push(0, 1'b0, 1'b0, 15, 1'b1, 2);
        end else begin
            set_tone(4, 2, 1'b0);
            push(25, 1'b0, 1'b1, 15, 1'b1, 2);
        end
        steps(20);
        en = 1'b1;
        run_windows(2);
        en = 1'b0;

        // Slower tone clears overflow
        set_tone(20, 10, 1'b0);
        steps(30);
        en = 1'b1;
        push(5, 1'b0, 1'b1, 5, 1'b0, 2);
        run_windows(2);

        // Drop en mid-window: gate_cnt is 1 here, go to 50
        steps(49);
        en = 1'b0;
        step();
        check("drop_busy_a", 32'(busy_a), 32'd0);
        check("drop_busy_b", 32'(busy_b), 32'd0);
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (fv_a === 1'b1 || fv_b === 1'b1) pulses++;
        end
        check("drop_no_pulse", 32'(pulses), 32'd0);
        check("drop_freq_hold_a", 32'(freq_a), 32'd5);
        check("drop_freq_hold_b", 32'(freq_b), 32'd5);
        check("drop_ovf_hold_b", 32'(ovf_b), 32'd0);

        // Re-enable latency
        en  = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
        end while (fv_a !== 1'b1 && lat < 300);
        check("reen_latency", 32'(lat), 32'(101 + SETTLE));
        check("reen_freq_a", 32'(freq_a), 32'd5);
        step();
        check("reen_pulse_width", 32'(fv_a), 32'd0);
        en = 1'b0;

        // 1-clk pulses every 10 clk
        set_tone(10, 1, 1'b0);
        steps(20);
        en = 1'b1;
        if (DEGLITCH) push(0, 1'b0, 1'b1, 0, 1'b0, 2);
        else          push(10, 1'b0, 1'b1, 10, 1'b0, 2);
        run_windows(2);
        en = 1'b0;
        steps(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
